// File: rtl/axibram_rsel.sv
// axibram_rsel: read-side source selector between a BRAM read engine and up
// to four memory-mapped data sources. A burst's start address is decoded to a
// source; enables are steered to it, the source's ready is returned, and read
// data is muxed back through a two-stage select pipeline that follows the
// engine's port/output-register latency.
// Optional feature: define AXIBRAM_RSEL_TIMEOUT_EN to add a not-ready watchdog
// that forces dev_ready high, substitutes ERR_DATA and flags err_timeout.
module axibram_rsel #(
  parameter int unsigned              ADDRESS_BITS   = 10,
  parameter logic [ADDRESS_BITS-1:0]  SRC0_BASE      = ADDRESS_BITS'(32'h000),
  parameter logic [ADDRESS_BITS-1:0]  SRC1_BASE      = ADDRESS_BITS'(32'h100),
  parameter logic [ADDRESS_BITS-1:0]  SRC2_BASE      = ADDRESS_BITS'(32'h200),
  parameter logic [ADDRESS_BITS-1:0]  SRC3_BASE      = ADDRESS_BITS'(32'h300),
  parameter logic [ADDRESS_BITS-1:0]  SRC0_MASK      = ADDRESS_BITS'(32'h300),
  parameter logic [ADDRESS_BITS-1:0]  SRC1_MASK      = ADDRESS_BITS'(32'h300),
  parameter logic [ADDRESS_BITS-1:0]  SRC2_MASK      = ADDRESS_BITS'(32'h300),
  parameter logic [ADDRESS_BITS-1:0]  SRC3_MASK      = ADDRESS_BITS'(32'h300),
  parameter logic [7:0]               TIMEOUT_CYCLES = 8'd255,
  parameter logic [31:0]              ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic [ADDRESS_BITS-1:0] pre_araddr,
  input  logic                    start_burst,
  input  logic                    bram_ren,
  input  logic                    bram_regen,
  input  logic [ADDRESS_BITS-1:0] bram_raddr,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic                    rlast,
  output logic                    dev_ready,
  output logic [31:0]             rdata,
  input  logic [3:0]              src_ready,
  input  logic [127:0]            src_rdata,
  output logic [3:0]              src_ren,
  output logic [3:0]              src_regen,
  output logic [ADDRESS_BITS-1:0] src_raddr,
  input  logic                    err_clr,
  output logic                    err_timeout,
  output logic                    err_unmapped,
  output logic [1:0]              err_src
);

  typedef enum logic [2:0] {
    SEL_S0   = 3'd0,
    SEL_S1   = 3'd1,
    SEL_S2   = 3'd2,
    SEL_S3   = 3'd3,
    SEL_NONE = 3'd4
  } sel_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [3:0] match;
  sel_t       dec_sel;
  sel_t       sel_a;
  sel_t       sel_p1;
  sel_t       sel_p2;
  logic [1:0] outstanding;
  logic [1:0] out_nxt;
  state_t     state;
  logic       r_done;
  logic       mux_ready;

  assign r_done = rvalid & rready & rlast;

  assign match[0] = ((pre_araddr & SRC0_MASK) == SRC0_BASE);
  assign match[1] = ((pre_araddr & SRC1_MASK) == SRC1_BASE);
  assign match[2] = ((pre_araddr & SRC2_MASK) == SRC2_BASE);
  assign match[3] = ((pre_araddr & SRC3_MASK) == SRC3_BASE);

  // Priority decode: lowest matching source wins, otherwise none
  always_comb begin
    dec_sel = SEL_NONE;
    for (int unsigned i = 0; i < 4; i++) begin
      if (dec_sel == SEL_NONE && match[i]) dec_sel = sel_t'(3'(i));
    end
  end

  // Address-stage select captured at burst start
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) sel_a <= SEL_NONE;
    else if (start_burst) sel_a <= dec_sel;
  end

  // Select pipeline advancing with the engine's read enable
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      sel_p1 <= SEL_NONE;
      sel_p2 <= SEL_NONE;
    end else if (bram_ren) begin
      sel_p1 <= sel_a;
      sel_p2 <= sel_p1;
    end
  end

  // Outstanding-burst count: simultaneous start and finish cancel out
  always_comb begin
    out_nxt = outstanding;
    if (start_burst && !r_done && outstanding != 2'd3)
      out_nxt = outstanding + 2'd1;
    else if (!start_burst && r_done && state == ST_ACTIVE)
      out_nxt = outstanding - 2'd1;
  end

  // Burst tracking state follows the outstanding count
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      state       <= ST_IDLE;
    end else begin
      outstanding <= out_nxt;
      state       <= (out_nxt == 2'd0) ? ST_IDLE : ST_ACTIVE;
    end
  end

  // Ready mux from the selected source; no source means always ready
  always_comb begin
    mux_ready = 1'b1;
    if (sel_a != SEL_NONE) mux_ready = src_ready[sel_a[1:0]];
  end

  // Enable steering and address pass-through
  always_comb begin
    src_ren   = '0;
    src_regen = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      src_ren[i]   = bram_ren   & (sel_a  == sel_t'(3'(i)));
      src_regen[i] = bram_regen & (sel_p1 == sel_t'(3'(i)));
    end
  end

  assign src_raddr = bram_raddr;

  // Sticky unmapped-access flag; a new set event beats a clear
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      err_unmapped <= 1'b0;
    end else begin
      if (err_clr) err_unmapped <= 1'b0;
      if (start_burst && dec_sel == SEL_NONE) err_unmapped <= 1'b1;
    end
  end

`ifdef AXIBRAM_RSEL_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_fired;
  logic       wd_hit;
  logic       tag_p1;
  logic       tag_p2;
  logic       err_timeout_q;
  logic [1:0] err_src_q;

  assign dev_ready = mux_ready | wd_fired;
  assign wd_hit    = (state == ST_ACTIVE) && !dev_ready && (out_nxt != 2'd0) &&
                     (wd_cnt == TIMEOUT_CYCLES - 8'd1);

  // Watchdog: counts stalled cycles while a burst is open; once fired it
  // holds ready high until the last outstanding burst finishes
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wd_cnt   <= '0;
      wd_fired <= 1'b0;
    end else if (state == ST_IDLE || out_nxt == 2'd0) begin
      wd_cnt   <= '0;
      wd_fired <= 1'b0;
    end else if (dev_ready) begin
      wd_cnt <= '0;
    end else if (wd_hit) begin
      wd_cnt   <= '0;
      wd_fired <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // Timeout tag travels with reads issued while the watchdog is fired
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      tag_p1 <= 1'b0;
      tag_p2 <= 1'b0;
    end else if (bram_ren) begin
      tag_p1 <= wd_fired;
      tag_p2 <= tag_p1;
    end
  end

  // Sticky timeout flag with the offending source captured
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      err_timeout_q <= 1'b0;
      err_src_q     <= '0;
    end else begin
      if (err_clr) begin
        err_timeout_q <= 1'b0;
        err_src_q     <= '0;
      end
      if (wd_hit) begin
        err_timeout_q <= 1'b1;
        err_src_q     <= sel_a[1:0];
      end
    end
  end

  assign err_timeout = err_timeout_q;
  assign err_src     = err_src_q;

  // Data mux; timed-out reads return the error pattern
  always_comb begin
    rdata = '0;
    if (sel_p2 != SEL_NONE) rdata = src_rdata[{sel_p2[1:0], 5'b0} +: 32];
    if (tag_p2) rdata = ERR_DATA;
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^{TIMEOUT_CYCLES, ERR_DATA};
  assign dev_ready   = mux_ready;
  assign err_timeout = 1'b0;
  assign err_src     = '0;

  // Data mux from the data-stage select
  always_comb begin
    rdata = '0;
    if (sel_p2 != SEL_NONE) rdata = src_rdata[{sel_p2[1:0], 5'b0} +: 32];
  end
`endif

endmodule

// File: tb/tb_axibram_rsel.sv
// Directed bench for axibram_rsel: decode, steering, data pipeline,
// back-to-back bursts, unmapped access, outstanding count, watchdog, reset.
module tb_axibram_rsel;
  logic         aclk = 1'b0;
  logic         rst;
  logic [9:0]   pre_araddr;
  logic         start_burst;
  logic         bram_ren;
  logic         bram_regen;
  logic [9:0]   bram_raddr;
  logic         rvalid;
  logic         rready;
  logic         rlast;
  logic         dev_ready;
  logic [31:0]  rdata;
  logic [3:0]   src_ready;
  logic [127:0] src_rdata;
  logic [3:0]   src_ren;
  logic [3:0]   src_regen;
  logic [9:0]   src_raddr;
  logic         err_clr;
  logic         err_timeout;
  logic         err_unmapped;
  logic [1:0]   err_src;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] W0 = 32'h0000_A000;
  localparam logic [31:0] W1 = 32'h1111_0001;
  localparam logic [31:0] W2 = 32'h2222_0002;
  localparam logic [31:0] W3 = 32'h3333_0003;

  axibram_rsel #(
    .ADDRESS_BITS   (10),
    .SRC3_BASE      (10'h001),
    .TIMEOUT_CYCLES (8'd4)
  ) dut (
    .aclk         (aclk),
    .rst          (rst),
    .pre_araddr   (pre_araddr),
    .start_burst  (start_burst),
    .bram_ren     (bram_ren),
    .bram_regen   (bram_regen),
    .bram_raddr   (bram_raddr),
    .rvalid       (rvalid),
    .rready       (rready),
    .rlast        (rlast),
    .dev_ready    (dev_ready),
    .rdata        (rdata),
    .src_ready    (src_ready),
    .src_rdata    (src_rdata),
    .src_ren      (src_ren),
    .src_regen    (src_regen),
    .src_raddr    (src_raddr),
    .err_clr      (err_clr),
    .err_timeout  (err_timeout),
    .err_unmapped (err_unmapped),
    .err_src      (err_src)
  );

  always #5 aclk = ~aclk;

  task automatic idle_inputs();
    start_burst = 1'b0;
    bram_ren    = 1'b0;
    bram_regen  = 1'b0;
    rvalid      = 1'b0;
    rready      = 1'b0;
    rlast       = 1'b0;
    err_clr     = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      idle_inputs();
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    end
    @(negedge aclk);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    pre_araddr = '0;
    bram_raddr = '0;
    src_ready  = 4'b1111;
    src_rdata  = {W3, W2, W1, W0};
    bram_ren   = 1'b1;
    bram_regen = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    total++; if (dev_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", dev_ready); end
    total++; if (src_ren !== 4'b0000) begin bad++; $display("FAIL reset_ren got=%b exp=0000", src_ren); end
    total++; if (src_regen !== 4'b0000) begin bad++; $display("FAIL reset_regen got=%b exp=0000", src_regen); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if ({err_unmapped, err_timeout, err_src} !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b exp=0000", {err_unmapped, err_timeout, err_src}); end
    total++; if (dut.outstanding !== 2'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", dut.outstanding); end
    @(negedge aclk);
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_decode_src1();
    @(negedge aclk);
    pre_araddr = 10'h105; start_burst = 1'b1;
    @(negedge aclk);
    idle_inputs(); bram_ren = 1'b1; bram_raddr = 10'h005;
    #1;
    total++; if (src_ren !== 4'b0010) begin bad++; $display("FAIL dec1_ren got=%b exp=0010", src_ren); end
    total++; if (src_raddr !== 10'h005) begin bad++; $display("FAIL dec1_raddr got=%h exp=005", src_raddr); end
    total++; if (dut.outstanding !== 2'd1) begin bad++; $display("FAIL dec1_outstanding got=%0d exp=1", dut.outstanding); end
    @(negedge aclk);
    bram_ren = 1'b1; bram_regen = 1'b1; bram_raddr = 10'h006;
    #1;
    total++; if (src_regen !== 4'b0010) begin bad++; $display("FAIL dec1_regen got=%b exp=0010", src_regen); end
    @(negedge aclk);
    bram_ren = 1'b0; bram_regen = 1'b1;
    #1;
    total++; if (src_ren !== 4'b0000) begin bad++; $display("FAIL dec1_ren_off got=%b exp=0000", src_ren); end
    total++; if (rdata !== W1) begin bad++; $display("FAIL dec1_rdata got=%h exp=%h", rdata, W1); end
    src_ready = 4'b1101;
    #1;
    total++; if (dev_ready !== 1'b0) begin bad++; $display("FAIL dec1_ready_mux got=%b exp=0", dev_ready); end
    src_ready = 4'b0010;
    #1;
    total++; if (dev_ready !== 1'b1) begin bad++; $display("FAIL dec1_ready_mux1 got=%b exp=1", dev_ready); end
    src_ready = 4'b1111;
    drain(1);
    #1;
    total++; if (dut.outstanding !== 2'd0) begin bad++; $display("FAIL dec1_drained got=%0d exp=0", dut.outstanding); end
  endtask

  task automatic test_back_to_back();
    @(negedge aclk);
    pre_araddr = 10'h000; start_burst = 1'b1;
    @(negedge aclk);
    idle_inputs(); bram_ren = 1'b1;
    #1;
    total++; if (src_ren !== 4'b0001) begin bad++; $display("FAIL b2b_ren0 got=%b exp=0001", src_ren); end
    @(negedge aclk);
    bram_ren = 1'b1; bram_regen = 1'b1;
    #1;
    total++; if (src_regen !== 4'b0001) begin bad++; $display("FAIL b2b_regen0 got=%b exp=0001", src_regen); end
    @(negedge aclk);
    bram_ren = 1'b1; bram_regen = 1'b1; start_burst = 1'b1; pre_araddr = 10'h200;
    #1;
    total++; if (src_ren !== 4'b0001) begin bad++; $display("FAIL b2b_ren_last got=%b exp=0001", src_ren); end
    @(negedge aclk);
    start_burst = 1'b0;
    #1;
    total++; if (src_ren !== 4'b0100) begin bad++; $display("FAIL b2b_ren2_a got=%b exp=0100", src_ren); end
    total++; if (src_regen !== 4'b0001) begin bad++; $display("FAIL b2b_regen_a got=%b exp=0001", src_regen); end
    total++; if (rdata !== W0) begin bad++; $display("FAIL b2b_rdata_a got=%h exp=%h", rdata, W0); end
    @(negedge aclk);
    #1;
    total++; if (src_ren !== 4'b0100) begin bad++; $display("FAIL b2b_ren2_b got=%b exp=0100", src_ren); end
    total++; if (src_regen !== 4'b0100) begin bad++; $display("FAIL b2b_regen_b got=%b exp=0100", src_regen); end
    total++; if (rdata !== W0) begin bad++; $display("FAIL b2b_rdata_b got=%h exp=%h", rdata, W0); end
    @(negedge aclk);
    #1;
    total++; if (rdata !== W2) begin bad++; $display("FAIL b2b_rdata_c got=%h exp=%h", rdata, W2); end
    total++; if (dut.outstanding !== 2'd2) begin bad++; $display("FAIL b2b_outstanding got=%0d exp=2", dut.outstanding); end
    drain(2);
    #1;
    total++; if (dut.outstanding !== 2'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", dut.outstanding); end
  endtask

  task automatic test_unmapped();
    @(negedge aclk);
    src_ready = 4'b0000; pre_araddr = 10'h3FF; start_burst = 1'b1;
    @(negedge aclk);
    idle_inputs(); bram_ren = 1'b1;
    #1;
    total++; if (err_unmapped !== 1'b1) begin bad++; $display("FAIL unm_flag got=%b exp=1", err_unmapped); end
    total++; if (dev_ready !== 1'b1) begin bad++; $display("FAIL unm_ready got=%b exp=1", dev_ready); end
    total++; if (src_ren !== 4'b0000) begin bad++; $display("FAIL unm_ren got=%b exp=0000", src_ren); end
    @(negedge aclk);
    bram_ren = 1'b1;
    @(negedge aclk);
    bram_ren = 1'b0; err_clr = 1'b1; start_burst = 1'b1;
    #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unm_rdata got=%h exp=0", rdata); end
    @(negedge aclk);
    start_burst = 1'b0; err_clr = 1'b1;
    #1;
    total++; if (err_unmapped !== 1'b1) begin bad++; $display("FAIL unm_set_wins got=%b exp=1", err_unmapped); end
    @(negedge aclk);
    err_clr = 1'b0;
    #1;
    total++; if (err_unmapped !== 1'b0) begin bad++; $display("FAIL unm_clear got=%b exp=0", err_unmapped); end
    src_ready = 4'b1111;
    drain(2);
  endtask

  task automatic test_outstanding();
    @(negedge aclk);
    pre_araddr = 10'h000; start_burst = 1'b1;
    @(negedge aclk);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    #1;
    total++; if (dut.outstanding !== 2'd1) begin bad++; $display("FAIL out_one got=%0d exp=1", dut.outstanding); end
    @(negedge aclk);
    idle_inputs(); rvalid = 1'b1; rready = 1'b1;
    #1;
    total++; if (dut.outstanding !== 2'd1) begin bad++; $display("FAIL out_same_cycle got=%0d exp=1", dut.outstanding); end
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      idle_inputs(); start_burst = 1'b1;
    end
    #1;
    total++; if (dut.outstanding !== 2'd1 + 2'd0 && dut.outstanding !== 2'd3) begin bad++; $display("FAIL out_nolast got=%0d exp=3", dut.outstanding); end
    @(negedge aclk);
    idle_inputs();
    #1;
    total++; if (dut.outstanding !== 2'd3) begin bad++; $display("FAIL out_sat_hi got=%0d exp=3", dut.outstanding); end
    drain(4);
    #1;
    total++; if (dut.outstanding !== 2'd0) begin bad++; $display("FAIL out_sat_lo got=%0d exp=0", dut.outstanding); end
  endtask

  task automatic test_timeout();
    @(negedge aclk);
    src_ready = 4'b1110; pre_araddr = 10'h000; start_burst = 1'b1;
`ifdef AXIBRAM_RSEL_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      @(negedge aclk);
      idle_inputs();
      #1;
      total++; if (dev_ready !== (k == 5)) begin bad++; $display("FAIL wd_ready_c%0d got=%b exp=%b", k, dev_ready, (k == 5)); end
    end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL wd_flag got=%b exp=1", err_timeout); end
    total++; if (err_src !== 2'd0) begin bad++; $display("FAIL wd_src got=%0d exp=0", err_src); end
    @(negedge aclk);
    bram_ren = 1'b1;
    @(negedge aclk);
    bram_ren = 1'b1;
    @(negedge aclk);
    bram_ren = 1'b0;
    #1;
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wd_rdata got=%h exp=deadbeef", rdata); end
    drain(1);
    #1;
    total++; if (dev_ready !== 1'b0) begin bad++; $display("FAIL wd_release got=%b exp=0", dev_ready); end
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    #1;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL wd_clear got=%b exp=0", err_timeout); end
`else
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      idle_inputs();
    end
    #1;
    total++; if (dev_ready !== 1'b0) begin bad++; $display("FAIL nowd_ready got=%b exp=0", dev_ready); end
    total++; if ({err_timeout, err_src} !== 3'b000) begin bad++; $display("FAIL nowd_err got=%b exp=000", {err_timeout, err_src}); end
    drain(1);
`endif
    src_ready = 4'b1111;
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    pre_araddr = 10'h200; start_burst = 1'b1;
    @(negedge aclk);
    idle_inputs(); bram_ren = 1'b1; bram_regen = 1'b1; src_ready = 4'b1011;
    #1;
    total++; if (src_ren !== 4'b0100) begin bad++; $display("FAIL rmid_ren_pre got=%b exp=0100", src_ren); end
    #2 rst = 1'b1;
    #1;
    total++; if (src_ren !== 4'b0000) begin bad++; $display("FAIL rmid_ren got=%b exp=0000", src_ren); end
    total++; if (dev_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", dev_ready); end
    total++; if (dut.outstanding !== 2'd0) begin bad++; $display("FAIL rmid_outstanding got=%0d exp=0", dut.outstanding); end
    @(negedge aclk);
    #1;
    total++; if (src_regen !== 4'b0000) begin bad++; $display("FAIL rmid_regen got=%b exp=0000", src_regen); end
    idle_inputs();
    rst = 1'b0;
    src_ready = 4'b1111;
  endtask

  initial begin
    test_reset();
    test_decode_src1();
    test_back_to_back();
    test_unmapped();
    test_outstanding();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/axibram_rsel.md
AXIBRAM_RSEL -- requirements
Module: axibram_rsel

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 10, meaning word-address width shared with the BRAM read engine.
REQ-002 SHALL have parameters SRC0_BASE..SRC3_BASE and SRC0_MASK..SRC3_MASK (ADDRESS_BITS wide), defaults base 0/0x100/0x200/0x300 and mask 0x300 each, meaning the source i decode window.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255 (8-bit, 1..255), meaning not-ready cycles before the watchdog fires.
REQ-004 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, meaning read data substituted after a timeout.
REQ-005 Port aclk, input, 1, meaning the single clock; reset is asynchronous and active-high.
REQ-006 Port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 Port pre_araddr, input, ADDRESS_BITS, meaning burst start address from the read engine.
REQ-008 Port start_burst, input, 1, meaning burst start; pre_araddr is valid in this cycle.
REQ-009 Ports bram_ren and bram_regen, input, 1 each, meaning the read engine port/output-register enables.
REQ-010 Port bram_raddr, input, ADDRESS_BITS, meaning the read engine address.
REQ-011 Ports rvalid, rready and rlast, input, 1 each, meaning the AXI R-channel snoop.
REQ-012 Port dev_ready, output, 1, meaning the muxed ready returned to the read engine.
REQ-013 Port rdata, output, 32, meaning the muxed read data.
REQ-014 Port src_ready, input, 4, meaning per-source ready.
REQ-015 Port src_rdata, input, 128, meaning four 32-bit data words, source i at bits [32i+31:32i].
REQ-016 Ports src_ren and src_regen, output, 4 each, meaning steered enables.
REQ-017 Port src_raddr, output, ADDRESS_BITS, meaning bram_raddr passed through.
REQ-018 Port err_clr, input, 1, meaning clear sticky errors.
REQ-019 Ports err_timeout and err_unmapped, output, 1 each, meaning sticky error flags.
REQ-020 Port err_src, output, 2, meaning the source that timed out.

Function
REQ-021 Decode SHALL select the lowest i with (pre_araddr & SRCi_MASK)==SRCi_BASE; no match SHALL select "none".
REQ-022 The select sel_a (3-bit: 4 sources plus none) SHALL be registered on start_burst; dev_ready SHALL depend only on sel_a and registers, never combinationally on start_burst, so the read engine has no loop.
REQ-023 dev_ready SHALL be src_ready[sel_a]; it SHALL be 1 when sel_a is none or the watchdog has fired.
REQ-024 src_ren[i] SHALL equal bram_ren & (sel_a==i); src_raddr SHALL equal bram_raddr.
REQ-025 On each bram_ren, sel_p1 SHALL load sel_a and sel_p2 SHALL load sel_p1; src_regen[i] SHALL equal bram_regen & (sel_p1==i).
REQ-026 rdata SHALL be src_rdata[sel_p2]; it SHALL be 0 when sel_p2 is none and ERR_DATA when the data-stage timeout tag is set.
REQ-027 The 2-bit outstanding counter SHALL increment on start_burst and decrement on rvalid&rready&rlast; when both occur in one cycle it SHALL be unchanged; it SHALL saturate at 3 and at 0.
REQ-028 State SHALL be IDLE when outstanding==0 and ACTIVE otherwise; in IDLE the watchdog counter SHALL be held at 0.
REQ-029 A start_burst decoding to none SHALL set err_unmapped.
REQ-030 A previous burst draining after a new start_burst SHALL be gated by the new source's ready (REQ-023); this behaviour is accepted.
REQ-031 err_clr SHALL clear all error flags; a set event in the same cycle SHALL win.

Reset
REQ-032 rst SHALL clear sel_a, sel_p1 and sel_p2 to none; outstanding, the watchdog counter and all error flags to 0; dev_ready to 1.
REQ-033 rst mid-burst SHALL abandon the burst and emit no spurious src_ren or src_regen.

Configuration
REQ-034 With AXIBRAM_RSEL_TIMEOUT_EN defined, in ACTIVE with dev_ready low the watchdog SHALL count up, clearing on any dev_ready high.
REQ-035 With AXIBRAM_RSEL_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL force dev_ready=1 until outstanding==0.
REQ-036 With AXIBRAM_RSEL_TIMEOUT_EN defined, the timeout SHALL set err_timeout, capture err_src=sel_a, and tag forced reads through the sel_p pipeline.
REQ-037 Without AXIBRAM_RSEL_TIMEOUT_EN, dev_ready SHALL be the pure mux, err_timeout and err_src SHALL be 0, and no counter logic SHALL exist.

Verification
REQ-038 start_burst with pre_araddr=0x105, src_ready=4'b1111 -> src_ren[1] pulses, src_regen[1] lags one ren, rdata=src_rdata word 1.
REQ-039 Back-to-back bursts 0x0 (len 3) then 0x200 -> the last two data beats of burst 1 come from src0 while src_ren[2] is already active.
REQ-040 pre_araddr=0x3FF with mask 0x300 and base 0x300 removed -> err_unmapped=1, dev_ready=1, rdata=0.
REQ-041 Macro on, TIMEOUT_CYCLES=4, src_ready[0] stuck 0 -> dev_ready=1 on the 5th cycle, rdata=0xDEADBEEF, err_src=0; err_clr clears the flags.
REQ-042 start_burst and rlast handshake in the same cycle at outstanding=1 -> outstanding stays 1.
REQ-043 rst asserted mid-burst -> all src_ren=0 next edge, dev_ready=1, outstanding=0.
